receptor_peso_serial: RTL and testbench

- Upstream stage of the dispenser control path: turns the raw UART line into a validated maximum-weight value plus a one-cycle command strobe.
- Contains a 8N1 serial receiver and an ASCII frame parser.
- The weight value feeds the comparator/gate logic; the command strobe feeds the main control FSM.
- Replaces the receive logic currently embedded in the datapath.

---
 rtl/receptor_defs.sv | 19 +
 rtl/rx_serial_8n1.sv | 106 ++++++++++
 rtl/receptor_peso_serial.sv | 114 +++++++++++
 tb/tb_receptor_peso_serial.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/receptor_defs.sv
// Shared constants for the serial weight receiver: parser state codes and the
// ASCII characters that delimit and make up a weight frame.
package receptor_defs;

  typedef enum logic [3:0] {
    ESPERA_P   = 4'd0,
    DIG0       = 4'd1,
    DIG1       = 4'd2,
    DIG2       = 4'd3,
    ESPERA_FIM = 4'd4,
    ATUALIZA   = 4'd5
  } estado_parser_t;

  localparam logic [7:0] DEF_CHAR_INICIO = 8'h50;
  localparam logic [7:0] DEF_CHAR_FIM    = 8'h0A;
  localparam logic [7:0] ASCII_0         = 8'h30;
  localparam logic [7:0] ASCII_9         = 8'h39;

endpackage

// File: rtl/rx_serial_8n1.sv
// UART byte receiver: 2-FF synchroniser, re-arm on idle line, mid-bit sampling.
// Optional even parity (8E1) when RX_PARIDADE_EN is defined; 8N1 otherwise.
module rx_serial_8n1 #(
  parameter int CICLOS_POR_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       byte_valido,
  output logic       erro_quadro
);

`ifdef RX_PARIDADE_EN
  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} estado_rx_t;
`else
  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARADA} estado_rx_t;
`endif

  localparam int                W_CONT   = $clog2(CICLOS_POR_BIT);
  localparam logic [W_CONT-1:0] FIM_BIT  = W_CONT'(CICLOS_POR_BIT - 1);
  localparam logic [W_CONT-1:0] MEIO_BIT = W_CONT'(CICLOS_POR_BIT / 2 - 1);

  logic              r_sinc_p0, r_sinc_p1;
  logic              r_armado;
  estado_rx_t        r_estado, w_prox;
  logic [W_CONT-1:0] r_cont;
  logic [2:0]        r_nbit;
  logic [7:0]        r_dado;
  logic              w_linha, w_zera, w_amostra;

  // stage p0/p1: metastability synchroniser, no reset on the data path
  always_ff @(posedge clock) begin
    r_sinc_p0 <= entrada_serial;
    r_sinc_p1 <= r_sinc_p0;
  end

  assign w_linha = r_sinc_p1;

  // A framing/parity error disarms so a stuck-low line cannot retrigger a start.
  always_ff @(posedge clock) begin
    if (reset)            r_armado <= 1'b0;
    else if (erro_quadro) r_armado <= 1'b0;
    else if (w_linha)     r_armado <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox;
  end

  always_comb begin
    w_prox      = r_estado;
    w_zera      = 1'b0;
    w_amostra   = 1'b0;
    byte_valido = 1'b0;
    erro_quadro = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_zera = 1'b1;
        if (r_armado && !w_linha) w_prox = INICIO;
      end
      INICIO: if (r_cont == MEIO_BIT) begin
        w_zera = 1'b1;
        w_prox = w_linha ? OCIOSO : DADOS;
      end
      DADOS: if (r_cont == FIM_BIT) begin
        w_zera    = 1'b1;
        w_amostra = 1'b1;
`ifdef RX_PARIDADE_EN
        if (r_nbit == 3'd7) w_prox = PARIDADE;
`else
        if (r_nbit == 3'd7) w_prox = PARADA;
`endif
      end
`ifdef RX_PARIDADE_EN
      PARIDADE: if (r_cont == FIM_BIT) begin
        w_zera = 1'b1;
        if (^{r_dado, w_linha}) begin
          erro_quadro = 1'b1;
          w_prox      = OCIOSO;
        end else begin
          w_prox = PARADA;
        end
      end
`endif
      PARADA: if (r_cont == FIM_BIT) begin
        w_zera      = 1'b1;
        w_prox      = OCIOSO;
        byte_valido = w_linha;
        erro_quadro = !w_linha;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    r_cont <= w_zera ? '0 : r_cont + 1'b1;
    if (r_estado == OCIOSO) r_nbit <= 3'd0;
    else if (w_amostra)     r_nbit <= r_nbit + 3'd1;
    if (w_amostra) r_dado <= {w_linha, r_dado[7:1]};
  end

  assign dado = r_dado;

endmodule

// File: rtl/receptor_peso_serial.sv
// Serial weight receiver: decodes "P<ddd>\n" frames into pesoMax plus a command
// strobe. Even-parity reception is enabled by defining RX_PARIDADE_EN.
module receptor_peso_serial
  import receptor_defs::*;
#(
  parameter int         CICLOS_POR_BIT = 434,
  parameter logic [7:0] CHAR_INICIO    = DEF_CHAR_INICIO,
  parameter logic [7:0] CHAR_FIM       = DEF_CHAR_FIM
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [9:0] pesoMax,
  output logic       pesoMaxIgualZero,
  output logic       comando,
  output logic       erro,
  output logic [3:0] db_estado
);

  logic [7:0]     w_dado;
  logic           w_byte_valido, w_erro_quadro;
  estado_parser_t r_estado, w_prox;
  logic [9:0]     r_acc, r_peso;
  logic           r_peso_zero, r_erro;
  logic           w_digito, w_limpa, w_soma, w_atualiza, w_erro_parse;

  function automatic logic [9:0] acumula(input logic [9:0] acc, input logic [7:0] c);
    logic [7:0] d;
    d = c - ASCII_0;
    return (acc << 3) + (acc << 1) + {2'b00, d};
  endfunction

  function automatic estado_parser_t proximo_digito(input estado_parser_t e);
    case (e)
      DIG0:    return DIG1;
      DIG1:    return DIG2;
      default: return ESPERA_FIM;
    endcase
  endfunction

  rx_serial_8n1 #(.CICLOS_POR_BIT(CICLOS_POR_BIT)) u_rx (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dado           (w_dado),
    .byte_valido    (w_byte_valido),
    .erro_quadro    (w_erro_quadro)
  );

  assign w_digito = (w_dado >= ASCII_0) && (w_dado <= ASCII_9);

  always_comb begin
    w_prox       = r_estado;
    w_limpa      = 1'b0;
    w_soma       = 1'b0;
    w_atualiza   = 1'b0;
    w_erro_parse = 1'b0;
    if (r_estado == ATUALIZA) begin
      w_prox = ESPERA_P;
    end else if (w_erro_quadro) begin
      w_prox = ESPERA_P;
    end else if (w_byte_valido) begin
      if (w_dado == CHAR_INICIO) begin
        w_prox  = DIG0;
        w_limpa = 1'b1;
      end else if (r_estado == ESPERA_FIM) begin
        if (w_dado == CHAR_FIM) begin
          w_prox     = ATUALIZA;
          w_atualiza = 1'b1;
        end else begin
          w_prox       = ESPERA_P;
          w_erro_parse = 1'b1;
        end
      end else if (r_estado != ESPERA_P) begin
        if (w_digito) begin
          w_soma = 1'b1;
          w_prox = proximo_digito(r_estado);
        end else begin
          w_prox       = ESPERA_P;
          w_erro_parse = 1'b1;
        end
      end
    end
  end

  // pesoMax is loaded on the LF byte so it is already valid while comando is high
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= ESPERA_P;
      r_peso      <= 10'd0;
      r_peso_zero <= 1'b1;
      r_erro      <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_erro   <= w_erro_quadro | w_erro_parse;
      if (w_atualiza) begin
        r_peso      <= r_acc;
        r_peso_zero <= (r_acc == 10'd0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_limpa)     r_acc <= 10'd0;
    else if (w_soma) r_acc <= acumula(r_acc, w_dado);
  end

  assign pesoMax          = r_peso;
  assign pesoMaxIgualZero = r_peso_zero;
  assign comando          = (r_estado == ATUALIZA);
  assign erro             = r_erro;
  assign db_estado        = r_estado;

endmodule

// File: tb/tb_receptor_peso_serial.sv
// Scoreboard bench for receptor_peso_serial with CICLOS_POR_BIT=16; expected
// comando/erro events are queued by the stimulus and popped by the monitor.
module tb_receptor_peso_serial;

  localparam int CPB = 16;
`ifdef RX_PARIDADE_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       clock, reset, entrada_serial;
  logic [9:0] pesoMax;
  logic       pesoMaxIgualZero, comando, erro;
  logic [3:0] db_estado;

  typedef struct {
    bit         eh_cmd;
    logic [9:0] peso;
    bit         zero;
    int         ciclo;
  } ev_t;

  ev_t q[$];
  ev_t ev_mon;
  int  n_vet = 0;
  int  n_err = 0;
  int  ciclo = 0;

  receptor_peso_serial #(.CICLOS_POR_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .entrada_serial   (entrada_serial),
    .pesoMax          (pesoMax),
    .pesoMaxIgualZero (pesoMaxIgualZero),
    .comando          (comando),
    .erro             (erro),
    .db_estado        (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic verifica(input string nome, input int atual, input int esperado);
    n_vet++;
    if (atual != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  // monitor: every comando/erro pulse must match the head of the queue
  always @(negedge clock) begin
    if (!reset) begin
      if (comando && erro) verifica("cmd_erro_exclusive", 1, 0);
      if (comando || erro) begin
        if (q.size() == 0) begin
          verifica(comando ? "unexpected_comando" : "unexpected_erro", 1, 0);
        end else begin
          ev_mon = q.pop_front();
          verifica("event_kind_is_cmd", int'(comando), int'(ev_mon.eh_cmd));
          if (comando && ev_mon.eh_cmd) begin
            verifica("pesoMax", int'(pesoMax), int'(ev_mon.peso));
            verifica("pesoMaxIgualZero", int'(pesoMaxIgualZero), int'(ev_mon.zero));
            verifica("comando_latency", ciclo, ev_mon.ciclo);
          end
        end
      end
    end
  end

  task automatic envia_byte(input logic [7:0] b, input bit stop_bom, input bit par_bom,
                            input int cmd_peso, input bit exp_erro);
    ev_t e;
    @(negedge clock);
    if (cmd_peso >= 0) begin
      e.eh_cmd = 1'b1;
      e.peso   = 10'(cmd_peso);
      e.zero   = (cmd_peso == 0);
      e.ciclo  = ciclo + LAT;
      q.push_back(e);
    end
    if (exp_erro) begin
      e.eh_cmd = 1'b0;
      e.peso   = 10'd0;
      e.zero   = 1'b0;
      e.ciclo  = -1;
      q.push_back(e);
    end
    entrada_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef RX_PARIDADE_EN
    entrada_serial = (^b) ^ !par_bom;
    repeat (CPB) @(negedge clock);
`endif
    entrada_serial = stop_bom;
    repeat (CPB) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // cmd_peso >= 0 expects a comando on the last byte; idx_erro marks a byte expected to raise erro
  task automatic envia_txt(input string s, input int cmd_peso, input int idx_erro);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      envia_byte(c, 1'b1, 1'b1, (i == s.len() - 1) ? cmd_peso : -1, i == idx_erro);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    entrada_serial = 1'b1;
    repeat (5) @(negedge clock);
    verifica("reset_pesoMax", int'(pesoMax), 0);
    verifica("reset_pesoMaxIgualZero", int'(pesoMaxIgualZero), 1);
    verifica("reset_comando", int'(comando), 0);
    verifica("reset_erro", int'(erro), 0);
    verifica("reset_db_estado", int'(db_estado), 0);
    reset = 1'b0;
    repeat (CPB) @(negedge clock);

    envia_txt("P123\n", 123, -1);
    envia_txt("P000\n", 0, -1);
    envia_txt("P123\n", 123, -1);
    envia_txt("P1A3\n", -1, 2);
    verifica("hold_after_bad_digit", int'(pesoMax), 123);
    verifica("state_after_bad_digit", int'(db_estado), 0);
    envia_txt("P999\n", 999, -1);
    envia_txt("P12P456\n", 456, -1);

    // stop bit forced low in the middle of a frame
    envia_txt("P4", -1, -1);
    verifica("state_mid_frame", int'(db_estado), 2);
    envia_byte(8'h35, 1'b0, 1'b1, -1, 1'b1);
    verifica("state_after_stop_error", int'(db_estado), 0);
    verifica("hold_after_stop_error", int'(pesoMax), 456);
    envia_txt("P321\n", 321, -1);

    // reset while the line is low inside the '2' of "P123\n"
    envia_txt("P1", -1, -1);
    @(negedge clock);
    entrada_serial = 1'b0;
    repeat (CPB + CPB / 2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    verifica("after_reset_pesoMax", int'(pesoMax), 0);
    verifica("after_reset_zero", int'(pesoMaxIgualZero), 1);
    verifica("after_reset_db_estado", int'(db_estado), 0);
`ifdef RX_PARIDADE_EN
    envia_byte(8'h50, 1'b1, 1'b1, -1, 1'b0);
    envia_byte(8'h35, 1'b1, 1'b0, -1, 1'b1);
    envia_txt("0\n", -1, -1);
    verifica("parity_error_pesoMax", int'(pesoMax), 0);
    verifica("parity_error_db_estado", int'(db_estado), 0);
`endif
    envia_txt("P050\n", 50, -1);

    repeat (50) @(negedge clock);
    verifica("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
    $finish;
  end

endmodule
